// File: rtl/ddc_tx_pkg.sv
// rtl/ddc_tx_pkg.sv - Shared types and constants for the DDC slave-FIFO transmitter.
package ddc_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    PKTEND = 3'd4
  } state_t;

  function automatic int beats_per_word(input int width_in, input int width_out);
    return width_in / width_out;
  endfunction

  localparam int DBG_STATE_LSB = 5;
  localparam int DBG_PEND      = 4;
  localparam int DBG_RD        = 3;
  localparam int DBG_WR        = 2;
  localparam int DBG_PKTEND    = 1;
  localparam int DBG_FULL_N    = 0;

endpackage

// File: rtl/ddc_slfifo_tx_if.sv
// rtl/ddc_slfifo_tx_if.sv - DDC FIFO read port and USB slave-FIFO write port bundle.
interface ddc_slfifo_tx_if #(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32
);
  logic                 rdempty;
  logic [WIDTH_IN-1:0]  q_data;
  logic                 strobe_rd;
  logic                 flag_full_n;
  logic                 slwr_n;
  logic                 pktend_n;
  logic [WIDTH_OUT-1:0] dq;

  modport master (
    input  rdempty, q_data, flag_full_n,
    output strobe_rd, slwr_n, pktend_n, dq
  );

  modport slave (
    output rdempty, q_data, flag_full_n,
    input  strobe_rd, slwr_n, pktend_n, dq
  );
endinterface

// File: rtl/ddc_tx_serializer.sv
// rtl/ddc_tx_serializer.sv - Splits one FIFO word into N bus beats, LSB slice first.
module ddc_tx_serializer
  import ddc_tx_pkg::*;
#(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0] dout,
  output logic                 last,
  output logic                 penult
);
  localparam int N  = beats_per_word(WIDTH_IN, WIDTH_OUT);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH_IN-1:0] sr;
  logic [BW-1:0]       beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      beat <= '0;
    end else if (load) begin
      sr   <= din;
      beat <= '0;
    end else if (shift) begin
      sr   <= sr >> WIDTH_OUT;
      beat <= beat + 1'b1;
    end
  end

  // penult lets the controller register the next FIFO read one beat early
  assign dout   = sr[WIDTH_OUT-1:0];
  assign last   = (beat == BW'(N - 1));
  assign penult = (beat == BW'(N - 2));
endmodule

// File: rtl/ddc_slfifo_tx.sv
// rtl/ddc_slfifo_tx.sv - DDC FIFO to USB slave-FIFO transmit engine with short-packet commit.
// Define DDC_TX_ZLP_EN to emit a zero-length packet when a burst ends on a packet boundary.
module ddc_slfifo_tx
  import ddc_tx_pkg::*;
#(
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32,
  parameter int PKT_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            pktend_in,
  input  logic            change_task,
  output logic            busy,
  output logic [7:0]      debug,
  ddc_slfifo_tx_if.master bus
);
  localparam int CW = $clog2(PKT_WORDS);

  state_t        state, state_d;
  logic [CW-1:0] pkt_cnt, cnt_d;
  logic          pend_pktend, pend_d;
  logic          clr_cnt, clr_d;
  logic          strobe_rd, strobe_d;
  logic          slwr_n, slwr_d;
  logic          pktend_n, pktend_d;
  logic [7:0]    debug_d;
  logic          fetch_ok, ser_last, ser_penult;

  ddc_tx_serializer #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .load   (state == LOAD),
    .shift  (state == SEND),
    .din    (bus.q_data),
    .dout   (bus.dq),
    .last   (ser_last),
    .penult (ser_penult)
  );

  assign fetch_ok = enable && !bus.rdempty && bus.flag_full_n;

  always_comb begin
    state_d  = state;
    cnt_d    = pkt_cnt;
    pend_d   = pend_pktend | pktend_in;
    clr_d    = clr_cnt;
    strobe_d = 1'b0;
    slwr_d   = 1'b1;
    pktend_d = 1'b1;
    debug_d  = '0;
    case (state)
      IDLE: begin
        if (pend_pktend && bus.rdempty) begin
          state_d = PKTEND;
`ifdef DDC_TX_ZLP_EN
          pktend_d = 1'b0;
`else
          pktend_d = (pkt_cnt == '0);
`endif
        end else if (fetch_ok) begin
          state_d  = FETCH;
          strobe_d = 1'b1;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = SEND;
        slwr_d  = 1'b0;
      end
      SEND: begin
        cnt_d = pkt_cnt + 1'b1;
        // FIFO data lands one cycle after the read, so the read is issued on the last beat
        if (ser_penult && fetch_ok && !pend_pktend)
          strobe_d = 1'b1;
        if (ser_last) begin
          state_d = strobe_rd ? LOAD : IDLE;
          if (clr_cnt) begin
            cnt_d = '0;
            clr_d = 1'b0;
          end
        end else begin
          slwr_d = 1'b0;
        end
      end
      PKTEND: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = pktend_in;
      end
      default: state_d = IDLE;
    endcase

    // a new task restarts packet accounting but never cuts a word in flight
    if (change_task) begin
      pend_d = 1'b0;
      if (state == LOAD || (state == SEND && !ser_last)) begin
        clr_d = 1'b1;
      end else begin
        cnt_d = '0;
        clr_d = 1'b0;
      end
    end

    debug_d[DBG_STATE_LSB +: 3] = state_d;
    debug_d[DBG_PEND]           = pend_d;
    debug_d[DBG_RD]             = strobe_d;
    debug_d[DBG_WR]             = ~slwr_d;
    debug_d[DBG_PKTEND]         = ~pktend_d;
    debug_d[DBG_FULL_N]         = bus.flag_full_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pkt_cnt     <= '0;
      pend_pktend <= 1'b0;
      clr_cnt     <= 1'b0;
      strobe_rd   <= 1'b0;
      slwr_n      <= 1'b1;
      pktend_n    <= 1'b1;
      busy        <= 1'b0;
      debug       <= '0;
    end else begin
      state       <= state_d;
      pkt_cnt     <= cnt_d;
      pend_pktend <= pend_d;
      clr_cnt     <= clr_d;
      strobe_rd   <= strobe_d;
      slwr_n      <= slwr_d;
      pktend_n    <= pktend_d;
      busy        <= (state_d != IDLE);
      debug       <= debug_d;
    end
  end

  assign bus.strobe_rd = strobe_rd;
  assign bus.slwr_n    = slwr_n;
  assign bus.pktend_n  = pktend_n;
endmodule

// File: tb/tb_ddc_slfifo_tx.sv
// tb/tb_ddc_slfifo_tx.sv - Randomized self-checking bench for ddc_slfifo_tx against a beat/packet model.
module tb_ddc_slfifo_tx;
  localparam int WIN  = 128;
  localparam int WOUT = 32;
  localparam int PKT  = 256;
  localparam int N    = WIN / WOUT;
`ifdef DDC_TX_ZLP_EN
  localparam bit ZLP = 1'b1;
`else
  localparam bit ZLP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pktend_in;
  logic       change_task;
  logic       busy;
  logic [7:0] debug;

  ddc_slfifo_tx_if #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT)) bus ();

  ddc_slfifo_tx #(.WIDTH_IN(WIN), .WIDTH_OUT(WOUT), .PKT_WORDS(PKT)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pktend_in   (pktend_in),
    .change_task (change_task),
    .busy        (busy),
    .debug       (debug),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [WIN-1:0]  fifo_q[$];
  logic [WOUT-1:0] exp_q[$];
  int cyc = 0, beats = 0, strobes = 0, pulses = 0, exp_pulses = 0;
  int pulse_beats = 0, fill = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1, last_strobe_cyc = -1;
  bit chk_period = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: observe DUT outputs on the falling edge and model the DDC FIFO
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!bus.slwr_n) begin
      if (exp_q.size() == 0) check("extra_beat", 1, 0);
      else check("dq", bus.dq, exp_q.pop_front());
      beats++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (!bus.pktend_n) begin
      pulses++;
      pulse_beats = beats;
      check("pktend_slwr_idle", bus.slwr_n, 1);
    end
    if (bus.strobe_rd) begin
      strobes++;
      if (chk_period && last_strobe_cyc >= 0) check("strobe_period", cyc - last_strobe_cyc, 5);
      last_strobe_cyc = cyc;
      if (fifo_q.size() == 0) check("pop_empty", 1, 0);
      else bus.q_data = fifo_q.pop_front();
    end
    bus.rdempty = (fifo_q.size() == 0);
  endtask

  task automatic push_word(input logic [WIN-1:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < N; i++) exp_q.push_back(w[i*WOUT +: WOUT]);
    fill = (fill + N) % PKT;
    bus.rdempty = 1'b0;
  endtask

  function automatic logic [WIN-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pulse_ctl(input bit pe, input bit ct);
    pktend_in   = pe;
    change_task = ct;
    if (ct) fill = 0;
    else if (pe) begin
      if (fill != 0 || ZLP) exp_pulses++;
      fill = 0;
    end
    tick();
    pktend_in   = 1'b0;
    change_task = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    enable = 1'b1;
    bus.flag_full_n = 1'b1;
    while (quiet < 6 && n < budget) begin
      tick();
      n++;
      if (!busy && bus.rdempty) quiet++;
      else quiet = 0;
    end
    check({tag, "_drain_in_time"}, n < budget, 1);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  initial begin
    int s0, b0, p0, n;
    rst = 1'b1; enable = 1'b0; pktend_in = 1'b0; change_task = 1'b0;
    bus.rdempty = 1'b1; bus.q_data = '0; bus.flag_full_n = 1'b1;
    repeat (3) tick();
    check("rst_strobe_rd", bus.strobe_rd, 0);
    check("rst_slwr_n", bus.slwr_n, 1);
    check("rst_pktend_n", bus.pktend_n, 1);
    check("rst_dq", bus.dq, 0);
    check("rst_busy", busy, 0);
    check("rst_debug", debug, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_busy", busy, 0);

    // single word, LSB slice first
    enable = 1'b1;
    s0 = strobes; b0 = beats; first_wr_cyc = -1;
    push_word(128'h44444444_33333333_22222222_11111111);
    drain("single", 200);
    check("single_strobes", strobes - s0, 1);
    check("single_beats", beats - b0, 4);
    check("single_latency", first_wr_cyc - last_strobe_cyc, 2);
    check("single_consecutive", last_wr_cyc - first_wr_cyc, 3);
    check("single_busy_after", busy, 0);
    pulse_ctl(1'b0, 1'b1);

    // 64 words back-to-back: exactly one packet, no commit
    enable = 1'b0;
    for (int i = 0; i < 64; i++) push_word(rand_word());
    s0 = strobes; b0 = beats;
    chk_period = 1'b1;
    last_strobe_cyc = -1;
    drain("b2b", 2000);
    chk_period = 1'b0;
    check("b2b_beats", beats - b0, 256);
    check("b2b_strobes", strobes - s0, 64);
    pulse_ctl(1'b1, 1'b0);
    drain("boundary_pktend", 200);

    // 10 words then burst end: short packet commit after beat 40
    b0 = beats;
    for (int i = 0; i < 10; i++) push_word(rand_word());
    pulse_ctl(1'b1, 1'b0);
    drain("short", 1000);
    check("short_pulse_after_data", pulse_beats - b0, 40);

    // watermark drops during beat 2 of word 2
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(rand_word());
    b0 = beats; n = 0;
    enable = 1'b1;
    while (beats != b0 + 2 * N + 3 && n < 100) begin tick(); n++; end
    check("flag_reach_beat2", beats - b0, 2 * N + 3);
    bus.flag_full_n = 1'b0;
    s0 = strobes;
    repeat (12) tick();
    check("flag_no_strobe", strobes - s0, 0);
    check("flag_word_done", beats - b0, 3 * N);
    drain("flag", 1000);
    check("flag_all_beats", beats - b0, 8 * N);

    // change_task wins over pktend_in; accounting restarts from zero
    for (int i = 0; i < 3; i++) push_word(rand_word());
    drain("ct_pre", 500);
    pulse_ctl(1'b1, 1'b1);
    drain("ct_pulse", 200);
    for (int i = 0; i < 64; i++) push_word(rand_word());
    pulse_ctl(1'b1, 1'b0);
    drain("ct_post", 3000);

    // random bursts with FIFO gaps, enable and watermark toggling
    for (int b = 0; b < 8; b++) begin
      int nw, pushed, kind;
      nw = $urandom_range(1, 70);
      pushed = 0;
      p0 = exp_pulses;
      while (pushed < nw) begin
        if ($urandom_range(0, 2) == 0) begin
          push_word(rand_word());
          pushed++;
        end
        enable = ($urandom_range(0, 3) != 0);
        bus.flag_full_n = ($urandom_range(0, 3) != 0);
        tick();
      end
      kind = $urandom_range(0, 2);
      if (kind == 0) pulse_ctl(1'b1, 1'b0);
      drain("rand", 4000);
      if (kind == 1) begin
        pulse_ctl(1'b0, 1'b1);
        drain("rand_ct", 200);
      end
      if (exp_pulses != p0) check("rand_pulse_after_data", pulse_beats, beats);
    end

    // asynchronous reset during beat 1 discards the word
    for (int i = 0; i < 2; i++) push_word(rand_word());
    b0 = beats; n = 0;
    while (beats != b0 + 2 && n < 50) begin tick(); n++; end
    check("rst_reach_beat1", beats - b0, 2);
    #1 rst = 1'b1;
    #1;
    check("arst_slwr_n", bus.slwr_n, 1);
    check("arst_strobe_rd", bus.strobe_rd, 0);
    check("arst_pktend_n", bus.pktend_n, 1);
    check("arst_dq", bus.dq, 0);
    check("arst_busy", busy, 0);
    fifo_q.delete();
    exp_q.delete();
    bus.rdempty = 1'b1;
    fill = 0;
    repeat (2) tick();
    rst = 1'b0;
    b0 = beats;
    push_word(rand_word());
    drain("post_rst", 200);
    check("post_rst_beats", beats - b0, N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddc_slfifo_tx.md
Name: ddc_slfifo_tx

Overview:
- Read-side consumer of the DDC sample FIFO, in the FIFO read clock domain.
- Pops 128-bit IQ words, serializes each into 32-bit beats and drives the USB bridge slave-FIFO write port (slwr_n/pktend_n/dq).
- Tracks USB packet fill and emits a short-packet commit when a DDC burst ends mid-packet.

Parameters:
- WIDTH_IN, 128, FIFO word width; must equal N*WIDTH_OUT.
- WIDTH_OUT, 32, slave-FIFO data bus width.
- PKT_WORDS, 256, WIDTH_OUT words per USB packet (1024 B); multiple of N; power of two.

Ports:
- clk, in, 1, FIFO read clock; drives all logic.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, permit new FIFO reads.
- rdempty, in, 1, DDC FIFO empty (includes burst-counter-empty).
- q_data, in, WIDTH_IN, FIFO read data; valid the cycle after strobe_rd.
- pktend_in, in, 1, one-cycle pulse at end of a DDC burst.
- change_task, in, 1, one-cycle pulse on new DDC command.
- flag_full_n, in, 1, bridge watermark flag; low = fewer than N words of space.
- strobe_rd, out, 1, FIFO read request.
- slwr_n, out, 1, slave-FIFO write strobe, active low.
- pktend_n, out, 1, slave-FIFO packet commit, active low.
- dq, out, WIDTH_OUT, slave-FIFO data.
- busy, out, 1, high whenever state is not IDLE.
- debug, out, 8, {state[2:0], pend_pktend, strobe_rd, ~slwr_n, ~pktend_n, flag_full_n}.

Behaviour:
- Reset values: strobe_rd=0, slwr_n=1, pktend_n=1, dq=0, busy=0. Internal: state=IDLE, pkt_cnt=0, beat=0, pend_pktend=0. All outputs registered.
- N = WIDTH_IN/WIDTH_OUT (4). pkt_cnt width = log2(PKT_WORDS).
- States:
  - IDLE: if pend_pktend && rdempty → PKTEND. Else if enable && !rdempty && flag_full_n → FETCH.
  - FETCH: strobe_rd=1 for exactly one cycle → LOAD.
  - LOAD: capture q_data into shift register, beat=0 → SEND.
  - SEND: slwr_n=0; dq = word[beat*W +: W], LSB slice first; pkt_cnt++ each beat, wrapping to 0 at PKT_WORDS. A full packet auto-commits with no pktend.
    - On beat N-1: if enable && !rdempty && flag_full_n && !pend_pktend, assert strobe_rd this cycle → LOAD. Otherwise → IDLE.
    - Steady-state throughput: N beats per N+1 cycles.
  - PKTEND: if pkt_cnt != 0, pktend_n=0 for one cycle, then pkt_cnt=0. pend_pktend cleared → IDLE.
- Latency: strobe_rd at cycle t, first slwr_n low at t+2.
- pktend_in sets pend_pktend in any state. The commit is issued only from IDLE once rdempty=1, so all burst data precedes it.
- pktend_in when pkt_cnt==0 (burst ended exactly on a packet boundary): no pktend_n pulse, unless the optional feature below is enabled.
- change_task:
  - clears pend_pktend;
  - clears pkt_cnt at the end of the current word (or immediately if IDLE/FETCH-free);
  - never truncates a word already in LOAD/SEND.
- enable deasserted mid-word: the word completes, then IDLE.
- flag_full_n is sampled only at fetch decisions. The watermark guarantees N free words, so it is never checked mid-word.
- Simultaneous pktend_in and change_task: change_task wins; pend_pktend stays 0.
- rst asserted mid-word: immediate return to reset values; the partial word is discarded.

Optional Feature:
- Macro DDC_TX_ZLP_EN.
- Defined: in PKTEND with pkt_cnt==0, pktend_n pulses low one cycle with slwr_n=1 (zero-length packet), so the host sees end-of-burst on exact boundaries.
- Undefined: no pulse when pkt_cnt==0.

Decomposition:
- Package ddc_tx_pkg holds:
  - state enum typedef (IDLE, FETCH, LOAD, SEND, PKTEND);
  - beat-count constant N derivation;
  - debug bit-position constants.
- One sub-module, ddc_tx_serializer: N-beat shift register with load/shift and a last-beat flag.

Test Plan:
- Single word 0x44444444_33333333_22222222_11111111, rdempty→0 then 1 → strobe_rd one cycle; dq=0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive slwr_n-low cycles starting 2 cycles after strobe_rd; busy then 0.
- 64 words back-to-back, FIFO never empty → 256 beats; strobe_rd every 5 cycles; pkt_cnt wraps to 0; no pktend_n.
- 10 words then pktend_in → after beat 40, rdempty=1, one pktend_n low pulse; pkt_cnt=0 after.
- 64 words then pktend_in → no pktend_n without DDC_TX_ZLP_EN; exactly one pulse with slwr_n=1 when DDC_TX_ZLP_EN is defined.
- flag_full_n=0 during beat 2 of word k → word k completes, no strobe_rd until flag_full_n=1. Separately, rst at beat 1 → outputs return to reset values the same cycle.
- change_task coincident with pktend_in after 3 words → no pktend_n, pkt_cnt=0, next word starts at pkt_cnt 0.
